// File: rtl/pbit_sweep_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : pbit_sweep_scheduler
// Brief   : Sequential Gibbs sweep controller for a p-bit activation fabric.
// Rev     : 1.0  initial release
// ============================================================================
module pbit_sweep_scheduler #(
  parameter int          N_NODES   = 8,
  parameter int          IDX_W     = $clog2(N_NODES),
  parameter int          ACT_W     = 4,
  parameter int          SWEEPS_W  = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [SWEEPS_W-1:0]        num_sweeps,
  input  logic                       greedy,
  input  logic [N_NODES-1:0]         clamp_mask,
  input  logic [N_NODES-1:0]         clamp_val,
  output logic [IDX_W-1:0]           act_idx,
  input  logic signed [ACT_W-1:0]    act_in,
  output logic [N_NODES-1:0]         state,
  output logic                       busy,
  output logic                       done,
  output logic [SWEEPS_W-1:0]        sweep_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EVAL   = 2'd1,
    S_UPDATE = 2'd2,
    S_FINISH = 2'd3
  } fsm_e;

  localparam logic [IDX_W-1:0] C_LAST_NODE = IDX_W'(N_NODES - 1);
  localparam logic [15:0]      C_LFSR_TAPS = 16'hB400;

  fsm_e                     fsm_q;
  logic [N_NODES-1:0]       state_q;
  logic [N_NODES-1:0]       clamp_mask_q;
  logic [IDX_W-1:0]         node_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     greedy_q;
  logic [SWEEPS_W-1:0]      sweep_cnt_q;
  logic [SWEEPS_W-1:0]      num_sweeps_q;
  logic [15:0]              lfsr_q;
  logic signed [ACT_W-1:0]  act_r_q;

  logic [15:0]              lfsr_d;
  logic signed [ACT_W-1:0]  rand_d;
  logic                     bit_d;
  logic [SWEEPS_W-1:0]      sweep_inc_d;

  always_comb begin
    lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? C_LFSR_TAPS : 16'h0000);
    rand_d      = greedy_q ? '0 : $signed(lfsr_q[ACT_W-1:0]);
    bit_d       = (act_r_q >= rand_d);
    sweep_inc_d = sweep_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= S_IDLE;
      state_q      <= '0;
      clamp_mask_q <= '0;
      node_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      greedy_q     <= 1'b0;
      sweep_cnt_q  <= '0;
      num_sweeps_q <= '0;
      lfsr_q       <= LFSR_SEED;
      act_r_q      <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (fsm_q)
        S_IDLE: begin
          if (start) begin
            num_sweeps_q <= num_sweeps;
            greedy_q     <= greedy;
            clamp_mask_q <= clamp_mask;
            state_q      <= (state_q & ~clamp_mask) | (clamp_val & clamp_mask);
            node_q       <= '0;
            sweep_cnt_q  <= '0;
            if (num_sweeps == '0) begin
              fsm_q  <= S_FINISH;
              done_q <= 1'b1;
            end else begin
              fsm_q  <= S_EVAL;
              busy_q <= 1'b1;
            end
          end
        end
        S_EVAL: begin
          act_r_q <= act_in;
          fsm_q   <= S_UPDATE;
        end
        S_UPDATE: begin
          // LFSR steps even for clamped nodes so the random stream is mask-independent.
          lfsr_q <= lfsr_d;
          if (!clamp_mask_q[node_q]) begin
            state_q[node_q] <= bit_d;
          end
          if (node_q == C_LAST_NODE) begin
            node_q      <= '0;
            sweep_cnt_q <= sweep_inc_d;
            if (sweep_inc_d == num_sweeps_q) begin
              fsm_q  <= S_FINISH;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              fsm_q <= S_EVAL;
            end
          end else begin
            node_q <= node_q + 1'b1;
            fsm_q  <= S_EVAL;
          end
        end
        S_FINISH: begin
          fsm_q <= S_IDLE;
        end
        default: begin
          fsm_q <= S_IDLE;
        end
      endcase
    end
  end

  assign act_idx   = node_q;
  assign state     = state_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sweep_cnt = sweep_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pbit_sweep_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_pbit_sweep_scheduler
// Brief   : Scoreboard bench with a behavioural Gibbs model and gate fabrics.
// Rev     : 1.0  initial release
// ============================================================================
module tb_pbit_sweep_scheduler;

  localparam int N = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              greedy = 1'b0;
  logic [7:0]        num_sweeps = '0;
  logic [7:0]        clamp_mask = '0;
  logic [7:0]        clamp_val = '0;
  logic [2:0]        act_idx;
  logic signed [3:0] act_in;
  logic [7:0]        state;
  logic              busy;
  logic              done;
  logic [7:0]        sweep_cnt;

  typedef struct {
    int         idx;
    logic [7:0] st;
  } exp_t;

  exp_t              exp_q[$];
  int                checks = 0;
  int                errors = 0;
  int                mode = 0;
  logic signed [3:0] cval = '0;
  logic [7:0]        mst = '0;
  logic [15:0]       mlfsr = 16'hACE1;
  int                busy_cycles = 0;
  int                done_cnt = 0;
  int                ones_cnt = 0;
  int                upd_cnt = 0;
  int                run_cyc = 0;
  int                bphase = 0;
  bit                pend = 1'b0;

  always #5 clk = ~clk;

  pbit_sweep_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_sweeps (num_sweeps),
    .greedy     (greedy),
    .clamp_mask (clamp_mask),
    .clamp_val  (clamp_val),
    .act_idx    (act_idx),
    .act_in     (act_in),
    .state      (state),
    .busy       (busy),
    .done       (done),
    .sweep_cnt  (sweep_cnt)
  );

  function automatic int bip(input logic b);
    return b ? 1 : -1;
  endfunction

  // Fabrics: 0 = NOT between nodes 0/1, 1 = p-AND (A=0, B=1, C=2), else constant.
  function automatic logic signed [3:0] fab(input int md, input logic [7:0] st, input int k,
                                            input logic signed [3:0] cv);
    int a;
    a = 0;
    case (md)
      0: if (k == 0) a = -bip(st[1]); else if (k == 1) a = -bip(st[0]);
      1: if (k == 0) a = -bip(st[1]) + 2 * bip(st[2]) + 1;
         else if (k == 1) a = -bip(st[0]) + 2 * bip(st[2]) + 1;
         else if (k == 2) a = 2 * bip(st[0]) + 2 * bip(st[1]) - 2;
      default: a = int'(cv);
    endcase
    return 4'(a);
  endfunction

  always_comb act_in = fab(mode, state, int'(act_idx), cval);

  task automatic model_run(input int ns, input logic g, input logic [7:0] m, input logic [7:0] v);
    logic signed [3:0] a;
    logic signed [3:0] r;
    exp_t e;
    mst = (mst & ~m) | (v & m);
    for (int s = 0; s < ns; s++) begin
      for (int k = 0; k < N; k++) begin
        a = fab(mode, mst, k, cval);
        r = g ? 4'sd0 : $signed(mlfsr[3:0]);
        if (!m[k]) mst[k] = (a >= r);
        mlfsr = mlfsr[0] ? ((mlfsr >> 1) ^ 16'hB400) : (mlfsr >> 1);
        e.idx = k;
        e.st  = mst;
        exp_q.push_back(e);
      end
    end
  endtask

  // Monitor: index checked in EVAL, written state checked the cycle after UPDATE.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      bphase = 0;
      pend   = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (busy) busy_cycles++;
      if (pend) begin
        pend = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_state: got %h, no expected entry queued", state);
        end else begin
          e = exp_q.pop_front();
          upd_cnt++;
          if (state[e.idx]) ones_cnt++;
          if (state !== e.st) begin
            errors++;
            $display("FAIL sb_state node %0d: got %h expected %h", e.idx, state, e.st);
          end
        end
      end
      if (busy) begin
        if (bphase == 0) begin
          bphase = 1;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_idx: got %0d, no expected entry queued", act_idx);
          end else if (int'(act_idx) != exp_q[0].idx) begin
            errors++;
            $display("FAIL sb_idx: got %0d expected %0d", act_idx, exp_q[0].idx);
          end
        end else begin
          bphase = 0;
          pend   = 1'b1;
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    mst   = '0;
    mlfsr = 16'hACE1;
    rst_n = 1'b1;
  endtask

  task automatic run(input int ns, input logic g, input logic [7:0] m, input logic [7:0] v);
    busy_cycles = 0;
    done_cnt    = 0;
    model_run(ns, g, m, v);
    @(negedge clk);
    num_sweeps = 8'(ns);
    greedy     = g;
    clamp_mask = m;
    clamp_val  = v;
    start      = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    run_cyc = 1;
    while (!done && run_cyc < 2 * N * ns + 10) begin
      @(negedge clk);
      run_cyc++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || act_idx !== 3'd0 || sweep_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: state=%h busy=%b done=%b idx=%0d cnt=%0d, required all zero",
               state, busy, done, act_idx, sweep_cnt);
    end
    do_reset();
  endtask

  task automatic test_not_gate();
    mode = 0;
    run(1, 1'b1, 8'hFC, 8'h00);
    checks++;
    if (run_cyc != 17) begin errors++; $display("FAIL not_done_latency: got %0d required 17", run_cyc); end
    checks++;
    if (state !== 8'h01) begin errors++; $display("FAIL not_state: got %h required 01", state); end
    checks++;
    if (busy_cycles != 16) begin errors++; $display("FAIL not_busy_cycles: got %0d required 16", busy_cycles); end
    checks++;
    if (sweep_cnt !== 8'd1 || done_cnt != 1) begin
      errors++;
      $display("FAIL not_count: sweep_cnt=%0d dones=%0d required 1/1", sweep_cnt, done_cnt);
    end
  endtask

  task automatic test_and_gate();
    mode = 1;
    run(2, 1'b1, 8'hFB, 8'h03);
    checks++;
    if (state !== 8'h07 || sweep_cnt !== 8'd2) begin
      errors++;
      $display("FAIL and_11: state=%h cnt=%0d required 07/2", state, sweep_cnt);
    end
    run(2, 1'b1, 8'hFB, 8'h01);
    checks++;
    if (state !== 8'h01 || sweep_cnt !== 8'd2) begin
      errors++;
      $display("FAIL and_10: state=%h cnt=%0d required 01/2", state, sweep_cnt);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL and_queue: %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_zero_sweeps();
    run(0, 1'b1, 8'hF0, 8'hA0);
    checks++;
    if (run_cyc != 1 || busy_cycles != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL zero_timing: latency=%0d busy=%0d dones=%0d required 1/0/1", run_cyc, busy_cycles, done_cnt);
    end
    checks++;
    if (state !== 8'hA1 || sweep_cnt !== 8'd0) begin
      errors++;
      $display("FAIL zero_state: state=%h cnt=%0d required A1/0", state, sweep_cnt);
    end
  endtask

  task automatic test_reset_midrun();
    bit seen_done;
    mode = 1;
    model_run(5, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    num_sweeps = 8'd5; greedy = 1'b0; clamp_mask = 8'h00; clamp_val = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (35) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || act_idx !== 3'd1) begin
      errors++;
      $display("FAIL midrun_position: busy=%b idx=%0d required 1/1", busy, act_idx);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || sweep_cnt !== 8'd0 || act_idx !== 3'd0) begin
      errors++;
      $display("FAIL midrun_reset: state=%h busy=%b done=%b cnt=%0d idx=%0d required zeros",
               state, busy, done, sweep_cnt, act_idx);
    end
    seen_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin errors++; $display("FAIL midrun_no_done: done pulsed, required none"); end
    exp_q.delete();
    mst   = '0;
    mlfsr = 16'hACE1;
    rst_n = 1'b1;
    run(3, 1'b0, 8'h00, 8'h00);
    checks++;
    if (run_cyc != 49 || sweep_cnt !== 8'd3 || state !== mst) begin
      errors++;
      $display("FAIL midrun_fresh: latency=%0d cnt=%0d state=%h required 49/3/%h", run_cyc, sweep_cnt, state, mst);
    end
  endtask

  task automatic test_saturated_act();
    mode = 2;
    cval = 4'sd7;
    ones_cnt = 0; upd_cnt = 0;
    run(64, 1'b0, 8'h00, 8'h00);
    checks++;
    if (ones_cnt != 512 || upd_cnt != 512 || state !== 8'hFF) begin
      errors++;
      $display("FAIL act_max: ones=%0d updates=%0d state=%h required 512/512/FF", ones_cnt, upd_cnt, state);
    end
    cval = -4'sd8;
    ones_cnt = 0; upd_cnt = 0;
    run(64, 1'b0, 8'h00, 8'h00);
    checks++;
    if (upd_cnt != 512 || ones_cnt < 17 || ones_cnt > 47) begin
      errors++;
      $display("FAIL act_min: ones=%0d of %0d required 17..47 of 512", ones_cnt, upd_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    mode = 1;
    busy_cycles = 0;
    done_cnt    = 0;
    model_run(2, 1'b1, 8'hFB, 8'h03);
    @(negedge clk);
    num_sweeps = 8'd2; greedy = 1'b1; clamp_mask = 8'hFB; clamp_val = 8'h03; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; num_sweeps = 8'd7;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (cyc >= 100) begin errors++; $display("FAIL b2b_done_timeout: no done within %0d cycles", cyc); end
    checks++;
    if (done_cnt != 1 || busy_cycles != 32 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ignored: dones=%0d busy_cycles=%0d busy=%b required 1/32/0", done_cnt, busy_cycles, busy);
    end
    checks++;
    if (sweep_cnt !== 8'd2 || state !== 8'h07 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_result: cnt=%0d state=%h queued=%0d required 2/07/0", sweep_cnt, state, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_not_gate();
    test_and_gate();
    test_zero_sweeps();
    test_reset_midrun();
    test_saturated_act();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pbit_sweep_scheduler.md
Name: pbit_sweep_scheduler

Overview:
Sequential Gibbs-sampling controller for a p-bit network built from the hard-coded gate activation blocks (COPY/NOT/AND/OR/HA/FA fabrics).
- Owns the N p-bit state register and presents it to the external combinational activation fabric.
- Visits one node at a time and samples the selected node's signed activation.
- Compares the activation against an LFSR random value and writes the new bit back before the next node is evaluated.
- Runs a programmable number of full sweeps per start command, with per-node clamping for inverted and forward-mode gate operation.

Parameters:
N_NODES, 8, number of p-bits in the network (2..64)
IDX_W, $clog2(N_NODES), node index width
ACT_W, 4, signed activation width, matching gate outputs (range -8..7)
SWEEPS_W, 8, width of the sweep-count operand
LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  1-cycle request to begin a run; sampled only in IDLE
num_sweeps  in  SWEEPS_W  sweeps per run; captured when start is accepted
greedy  in  1  when 1, the random value is forced to 0 (deterministic mode); captured at start
clamp_mask  in  N_NODES  1 = node is clamped and never sampled; captured at start
clamp_val  in  N_NODES  value forced onto each clamped node; captured at start
act_idx  out  IDX_W  index of the node under evaluation
act_in  in  ACT_W signed  activation of node act_idx, driven combinationally by the fabric from state
state  out  N_NODES  p-bit states, bit k = node k (1 = +1, 0 = -1)
busy  out  1  run in progress
done  out  1  1-cycle pulse at end of run
sweep_cnt  out  SWEEPS_W  number of sweeps completed in the current or last run

Behaviour:
Reset, asynchronous on rst_n low:
- state=0, act_idx=0, busy=0, done=0, sweep_cnt=0, LFSR=LFSR_SEED, FSM=IDLE.
- Reset asserted mid-run aborts the run immediately; no done pulse is issued.

FSM states: IDLE, EVAL, UPDATE, FINISH.

IDLE:
- busy=0.
- On start=1 at a clock edge:
  - capture num_sweeps, greedy, clamp_mask and clamp_val;
  - apply state[k]=clamp_val[k] for every k with clamp_mask[k]=1;
  - set node=0 and sweep_cnt=0;
  - go to EVAL, or to FINISH if num_sweeps=0.
- start is ignored in every other state; it is not queued.

EVAL (1 cycle):
- act_idx=node.
- Register act_in into act_r.

UPDATE (1 cycle):
- Random value r = signed LFSR[ACT_W-1:0], or 0 when greedy=1.
- If the node is not clamped: state[node] = (act_r >= r), compared signed.
- Clamped nodes keep their value.
- The LFSR advances exactly once per UPDATE, including for clamped nodes. It is a 16-bit Galois LFSR with taps x^16+x^14+x^13+x^11+1.
- If node=N_NODES-1:
  - set node=0 and increment sweep_cnt;
  - go to FINISH if sweep_cnt+1==num_sweeps, otherwise go to EVAL.
- Otherwise set node=node+1 and go to EVAL.

FINISH (1 cycle):
- done=1, busy=0, then go to IDLE.

Timing and state visibility:
- busy=1 in EVAL and UPDATE; it rises the cycle after start is accepted.
- A run lasts 2*N_NODES*num_sweeps busy cycles, then one FINISH cycle.
- Each state write is visible to the fabric at the next EVAL, giving strict sequential Gibbs ordering.

Arithmetic and hold rules:
- The compare is ACT_W-bit signed, no extension needed.
- With greedy=0, act=7 yields 1 with probability 1, and act=-8 yields 1 with probability 1/16.
- sweep_cnt saturates at num_sweeps. It holds its value in IDLE until the next accepted start.
- state and act_idx hold in IDLE and FINISH.

Test Plan:
1. N_NODES=2, fabric = NOT gate (act0=-(2s1-1), act1=-(2s0-1)), greedy=1, num_sweeps=1, start from reset -> act0=+1 so s0=1; act1=-1 so s1=0. state=2'b01, busy high for 4 cycles, done pulses on cycle 5 after start.
2. N_NODES=3, p_AND fabric, greedy=1, clamp_mask=3'b011, clamp_val=3'b011, num_sweeps=2 -> C converges to 1, state=3'b111. With clamp_val=3'b001 -> state=3'b001. sweep_cnt=2 at done.
3. num_sweeps=0 -> no busy cycles; done asserts the cycle after start; state changes only through the clamp load.
4. Reset asserted mid-run (during UPDATE of node 1, sweep 3 of 5) -> state=0, busy=0, no done pulse, LFSR=16'hACE1. A fresh start runs normally.
5. greedy=0, act_in tied to +7 for all nodes, 64 sweeps -> every bit is 1 on every UPDATE. Tied to -8 -> fraction of 1s within 1/16±0.03. The LFSR never reaches 0.
6. start pulsed while busy, plus start coincident with FINISH -> both ignored; the run completes with an unchanged sweep count and exactly one done pulse.
